// File: rtl/cam_pkg.sv
// Shared types and constants for the camera power-up / configuration sequencer.
package cam_pkg;

  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    CamOff    = 3'd0,
    CamPwrup  = 3'd1,
    CamTrig   = 3'd2,
    CamWait   = 3'd3,
    CamSettle = 3'd4,
    CamReady  = 3'd5,
    CamPwrdn  = 3'd6,
    CamFail   = 3'd7
  } cam_seq_state_e;

  function automatic int unsigned cam_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_dly_cnt.sv
// Loadable down-counter shared by every delay state; expire_o is high for the single
// cycle the count sits at 1, so a state loaded with N lasts exactly N cycles.
module cam_dly_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] cnt_o,
  output logic             expire_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign expire_o = (cnt_q == Width'(1));

endmodule

// File: rtl/cam_init_seq.sv
// Camera sensor power-up and I2C configuration sequencer. Define CAM_INIT_SEQ_TIMEOUT_EN
// to enable the writer-done timeout with power-cycle retries and the sticky FAIL state.
module cam_init_seq
  import cam_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES   = 2_000_000,
  parameter int unsigned SETTLE_CYCLES  = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned PWRDN_CYCLES   = 1_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               cam_en_o,
  output logic               i2c_rst_o,
  output logic               i2c_trig_o,
  input  logic               i2c_done_i,
  output logic               ready_o,
  output logic               error_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int unsigned MaxDly = cam_max(cam_max(PWRUP_CYCLES, SETTLE_CYCLES),
                                           cam_max(TIMEOUT_CYCLES, PWRDN_CYCLES));
  localparam int unsigned CntW   = $clog2(MaxDly) + 1;

  cam_seq_state_e     state_d, state_q;
  logic [RETRY_W-1:0] retry_d, retry_q;
  logic               err_d, err_q;
  logic               cam_en_d, cam_en_q;
  logic               i2c_rst_d, i2c_rst_q;
  logic               i2c_trig_d, i2c_trig_q;
  logic               ready_d, ready_q;

  logic               cnt_load;
  logic [CntW-1:0]    cnt_load_val;
  logic [CntW-1:0]    cnt;
  logic               cnt_exp;

  cam_dly_cnt #(
    .Width (CntW)
  ) u_dly_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .cnt_o      (cnt),
    .expire_o   (cnt_exp)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    err_d   = err_q;
    if (stop_i) begin
      // stop also blocks a start while already in OFF
      state_d = CamOff;
    end else begin
      case (state_q)
        CamOff: begin
          if (start_i) begin
            state_d = CamPwrup;
            retry_d = '0;
            err_d   = 1'b0;
          end
        end
        CamPwrup:  if (cnt_exp) state_d = CamTrig;
        CamTrig:   state_d = CamWait;
        CamWait: begin
          if (i2c_done_i) begin
            state_d = CamSettle;
`ifdef CAM_INIT_SEQ_TIMEOUT_EN
          end else if (cnt_exp) begin
            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
              state_d = CamPwrdn;
              retry_d = retry_q + 1'b1;
            end else begin
              state_d = CamFail;
              err_d   = 1'b1;
            end
`endif
          end
        end
        CamSettle: if (cnt_exp) state_d = CamReady;
        CamReady:  state_d = CamReady;
        CamPwrdn:  if (cnt_exp) state_d = CamPwrup;
        CamFail:   state_d = CamFail;
        default:   state_d = CamOff;
      endcase
    end
  end

  // Every state entry reloads the counter with that state's dwell time.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      CamPwrup:  cnt_load_val = CntW'(PWRUP_CYCLES);
`ifdef CAM_INIT_SEQ_TIMEOUT_EN
      CamWait:   cnt_load_val = CntW'(TIMEOUT_CYCLES);
      CamPwrdn:  cnt_load_val = CntW'(PWRDN_CYCLES);
`endif
      CamSettle: cnt_load_val = CntW'(SETTLE_CYCLES);
      default:   cnt_load_val = '0;
    endcase
  end

  // Outputs decoded from the next state and registered so they track state_q exactly.
  always_comb begin
    cam_en_d   = 1'b0;
    i2c_rst_d  = 1'b1;
    i2c_trig_d = 1'b0;
    ready_d    = 1'b0;
    case (state_d)
      CamPwrup: cam_en_d = 1'b1;
      CamTrig: begin
        cam_en_d   = 1'b1;
        i2c_rst_d  = 1'b0;
        i2c_trig_d = 1'b1;
      end
      CamWait, CamSettle: begin
        cam_en_d  = 1'b1;
        i2c_rst_d = 1'b0;
      end
      CamReady: begin
        cam_en_d = 1'b1;
        ready_d  = 1'b1;
      end
      default: begin
        cam_en_d  = 1'b0;
        i2c_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CamOff;
      retry_q    <= '0;
      err_q      <= 1'b0;
      cam_en_q   <= 1'b0;
      i2c_rst_q  <= 1'b1;
      i2c_trig_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      cam_en_q   <= cam_en_d;
      i2c_rst_q  <= i2c_rst_d;
      i2c_trig_q <= i2c_trig_d;
      ready_q    <= ready_d;
    end
  end

  assign cam_en_o    = cam_en_q;
  assign i2c_rst_o   = i2c_rst_q;
  assign i2c_trig_o  = i2c_trig_q;
  assign ready_o     = ready_q;
  assign error_o     = err_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Scoreboard bench for cam_init_seq: each sequence is planned as a timeline of expected
// output-vector changes; a monitor pops and compares whenever the outputs change.
module tb_cam_init_seq;

  localparam int P    = 10;
  localparam int S    = 5;
  localparam int TO   = 50;
  localparam int MAXR = 2;
  localparam int PD   = 8;
`ifdef CAM_INIT_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [8:0] vec;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       i2c_done_i = 1'b0;
  logic       cam_en_o, i2c_rst_o, i2c_trig_o, ready_o, error_o;
  logic [3:0] retry_cnt_o;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  ev_t        sb[$];
  logic [8:0] m_vec;
  logic [8:0] mon_prev;
  logic [8:0] mon_cur;
  ev_t        mon_ev;
  bit         mon_en = 1'b0;

  cam_init_seq #(
    .PWRUP_CYCLES   (P),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRIES    (MAXR),
    .PWRDN_CYCLES   (PD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .cam_en_o    (cam_en_o),
    .i2c_rst_o   (i2c_rst_o),
    .i2c_trig_o  (i2c_trig_o),
    .i2c_done_i  (i2c_done_i),
    .ready_o     (ready_o),
    .error_o     (error_o),
    .retry_cnt_o (retry_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {cam_en, i2c_rst, i2c_trig, ready, error, retry[3:0]}
  function automatic logic [8:0] mk(bit en, bit rs, bit tr, bit rd, bit er, int rt);
    return {en, rs, tr, rd, er, 4'(rt)};
  endfunction

  localparam logic [8:0] RST_VEC = 9'b0_1_0_0_0_0000;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {cam_en_o, i2c_rst_o, i2c_trig_o, ready_o, error_o, retry_cnt_o};
      if (mon_cur !== mon_prev) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=%b (unchanged)",
                   cyc, mon_cur, mon_prev);
        end else begin
          mon_ev = sb.pop_front();
          if (mon_ev.vec !== mon_cur || mon_ev.cyc != cyc) begin
            n_bad++;
            $display("FAIL out_change cyc=%0d got=%b required=%b at cyc=%0d",
                     cyc, mon_cur, mon_ev.vec, mon_ev.cyc);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void push_ev(input int c, input logic [8:0] v);
    if (v != m_vec) begin
      sb.push_back(ev_t'{c, v});
      m_vec = v;
    end
  endfunction

  task automatic drain_check(input string name);
    wait_to(cyc + 2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s pending_events=%0d required=0 next_cyc=%0d next_vec=%b",
               name, sb.size(), sb[0].cyc, sb[0].vec);
      sb.delete();
    end
  endtask

  // One start-initiated sequence. dN: done delay after trigger for attempt N (<1 = never);
  // kill_rel: cycles after start to apply stop/reset (<1 = a few cycles after READY/FAIL).
  task automatic run_seq(input int d0, input int d1, input int d2, input int kill_rel,
                         input bit kill_rst);
    int  dl[3];
    ev_t plan[$];
    int  s0, u, t, r, end_c, kill_c, done_c, h, fin;
    dl     = '{d0, d1, d2};
    s0     = cyc + 1;
    u      = s0 + 1;
    r      = 0;
    done_c = -1;
    end_c  = 0;
    plan.push_back(ev_t'{u, mk(1, 1, 0, 0, 0, 0)});
    while (1) begin
      t = u + P;
      plan.push_back(ev_t'{t, mk(1, 0, 1, 0, 0, r)});
      plan.push_back(ev_t'{t + 1, mk(1, 0, 0, 0, 0, r)});
      if (TO_EN && (dl[r] < 1 || dl[r] > TO)) begin
        if (r < MAXR) begin
          r++;
          plan.push_back(ev_t'{t + TO + 1, mk(0, 1, 0, 0, 0, r)});
          u = t + TO + PD + 1;
          plan.push_back(ev_t'{u, mk(1, 1, 0, 0, 0, r)});
        end else begin
          end_c = t + TO + 1;
          plan.push_back(ev_t'{end_c, mk(0, 1, 0, 0, 1, r)});
          break;
        end
      end else begin
        done_c = t + ((dl[r] < 1) ? 1 : dl[r]);
        end_c  = done_c + 1 + S;
        plan.push_back(ev_t'{end_c, mk(1, 1, 0, 1, 0, r)});
        break;
      end
    end
    kill_c = (kill_rel > 0) ? s0 + kill_rel : end_c + 3;
    foreach (plan[i]) begin
      if (plan[i].cyc <= kill_c) push_ev(plan[i].cyc, plan[i].vec);
    end
    if (kill_rst) push_ev(kill_c + 1, RST_VEC);
    else          push_ev(kill_c + 1, {4'b0100, m_vec[4:0]});
    h = 1 + int'($urandom_range(0, P - 2));
    if (h > kill_c - s0) h = kill_c - s0;
    fin = kill_c + 3;
    if (done_c + 2 > fin) fin = done_c + 2;
    for (int c = s0; c <= fin; c++) begin
      wait_to(c);
      start_i    = (c < s0 + h);
      i2c_done_i = (done_c >= 0 && c >= done_c && c < fin);
      if (kill_rst) rst_i  = (c >= kill_c && c < kill_c + 2);
      else          stop_i = (c >= kill_c && c < kill_c + 2);
    end
    drain_check("seq_drain");
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dd[3];
    int kr;
    m_vec = RST_VEC;
    wait_to(2);
    n_cmp++;
    mon_cur = {cam_en_o, i2c_rst_o, i2c_trig_o, ready_o, error_o, retry_cnt_o};
    if (mon_cur !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_state got=%b required=%b", mon_cur, RST_VEC);
    end
    mon_prev = RST_VEC;
    mon_en   = 1'b1;
    rst_i    = 1'b0;
    wait_to(cyc + 2);

    run_seq(20, 20, 20, -1, 1'b0);          // nominal, done 20 after trigger
    run_seq(40, 40, 40, P + 12, 1'b0);      // stop mid-WAIT, done arrives later
    run_seq(5, 5, 5, -1, 1'b0);             // restart gives full power-up
    run_seq(5, 5, 5, 4, 1'b0);              // stop during PWRUP
    run_seq(7, 7, 7, -1, 1'b1);             // sync reset while READY

    // start with stop held in OFF must not begin a sequence
    wait_to(cyc + 1);
    start_i = 1'b1;
    stop_i  = 1'b1;
    wait_to(cyc + 5);
    start_i = 1'b0;
    stop_i  = 1'b0;
    drain_check("start_blocked_by_stop");

    if (TO_EN) begin
      run_seq(0, 0, 0, -1, 1'b0);           // three timeouts -> FAIL
      run_seq(0, 15, 0, -1, 1'b0);          // one retry then READY
      run_seq(TO, 0, 0, -1, 1'b0);          // done on the expiry cycle wins
      run_seq(TO + 1, 3, 0, -1, 1'b0);      // done one cycle late -> retry
    end

    for (int k = 0; k < 10; k++) begin
      for (int a = 0; a < 3; a++) begin
        dd[a] = TO_EN ? int'($urandom_range(0, TO + 10)) : int'($urandom_range(1, 60));
      end
      kr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 150)) : -1;
      run_seq(dd[0], dd[1], dd[2], kr, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
